// File: rtl/alarm_trigger_pkg.sv
// Alarm trigger shared definitions.
// State encoding and time constants.
package alarm_trigger_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ARMED  = 2'd1;
  localparam logic [1:0] ST_RING   = 2'd2;
  localparam logic [1:0] ST_SNOOZE = 2'd3;

  localparam logic [3:0] ALARM_UNSET  = 4'hF;
  localparam int         SECS_PER_MIN = 60;

  typedef enum logic [1:0] {
    IDLE   = ST_IDLE,
    ARMED  = ST_ARMED,
    RING   = ST_RING,
    SNOOZE = ST_SNOOZE
  } state_t;

  function automatic logic digit_unset(
    input logic [3:0] d
  );
    return d == ALARM_UNSET;
  endfunction

endpackage

// File: rtl/alarm_trigger_if.sv
// Alarm trigger bus: time, stored alarm,
// keys in; ring/snooze status and clear out.
interface alarm_trigger_if;

  logic       TICK_1HZ;
  logic [3:0] T_H10;
  logic [3:0] T_H1;
  logic [3:0] T_M10;
  logic [3:0] T_M1;
  logic [3:0] T_S10;
  logic [3:0] T_S1;
  logic [3:0] SA_H10;
  logic [3:0] SA_H1;
  logic [3:0] SA_M10;
  logic [3:0] SA_M1;
  logic       DONE_SET;
  logic       STOP_KEY;
  logic       SNOOZE_KEY;
  logic       RINGING;
  logic       BUZZER;
  logic       SNOOZE_ACTIVE;
  logic [1:0] SNOOZE_CNT;
  logic       DISABLE_TRIGGER;

  modport master (
    output TICK_1HZ,
    output T_H10, T_H1, T_M10, T_M1,
    output T_S10, T_S1,
    output SA_H10, SA_H1, SA_M10, SA_M1,
    output DONE_SET, STOP_KEY, SNOOZE_KEY,
    input  RINGING, BUZZER, SNOOZE_ACTIVE,
    input  SNOOZE_CNT, DISABLE_TRIGGER
  );

  modport slave (
    input  TICK_1HZ,
    input  T_H10, T_H1, T_M10, T_M1,
    input  T_S10, T_S1,
    input  SA_H10, SA_H1, SA_M10, SA_M1,
    input  DONE_SET, STOP_KEY, SNOOZE_KEY,
    output RINGING, BUZZER, SNOOZE_ACTIVE,
    output SNOOZE_CNT, DISABLE_TRIGGER
  );

endinterface

// File: rtl/alarm_trigger_countdown.sv
// Loadable tick-enabled down-counter.
// Expire fires on the tick that drains it.
module alarm_countdown #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         expire
);

  logic [W-1:0] cnt;

  // Load wins over counting; hold at zero once drained.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (en && cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign expire = en && (cnt == W'(1));

endmodule

// File: rtl/alarm_trigger.sv
// Alarm trigger: rings on time match, handles
// stop, snooze and timeout, clears stored alarm.
module alarm_trigger
  import alarm_trigger_pkg::*;
#(
  parameter int RING_SECONDS   = 60,
  parameter int SNOOZE_MINUTES = 5,
  parameter int MAX_SNOOZE     = 3
) (
  input logic           CLK,
  input logic           RESET,
  alarm_trigger_if.slave bus
);

  localparam logic [7:0] RING_LOAD =
    8'(RING_SECONDS);
  localparam logic [9:0] SNZ_LOAD =
    10'(SNOOZE_MINUTES * SECS_PER_MIN);
  localparam logic [1:0] SNZ_MAX =
    2'(MAX_SNOOZE);

  state_t     state, state_d;
  logic       phase, phase_d;
  logic [1:0] snz_used, snz_used_d;
  logic       dis_d, stop_req;
  logic       alarm_set, match;
  logic       ring_load, ring_en, ring_exp;
  logic       snz_load, snz_en, snz_exp;
  logic       ringing_q, buzzer_q;
  logic       snooze_q, dis_q;

  assign alarm_set = !(digit_unset(bus.SA_H10) ||
                       digit_unset(bus.SA_H1)  ||
                       digit_unset(bus.SA_M10) ||
                       digit_unset(bus.SA_M1));

  assign match = bus.TICK_1HZ &&
                 bus.T_H10 == bus.SA_H10 &&
                 bus.T_H1  == bus.SA_H1  &&
                 bus.T_M10 == bus.SA_M10 &&
                 bus.T_M1  == bus.SA_M1  &&
                 bus.T_S10 == 4'd0 &&
                 bus.T_S1  == 4'd0;

  assign ring_load = state_d == RING &&
                     state != RING;
  assign snz_load  = state_d == SNOOZE &&
                     state != SNOOZE;
  assign ring_en   = bus.TICK_1HZ &&
                     state == RING;
  assign snz_en    = bus.TICK_1HZ &&
                     state == SNOOZE;

  alarm_countdown #(.W(8)) u_ring (
    .clk      (CLK),
    .rst      (RESET),
    .load     (ring_load),
    .load_val (RING_LOAD),
    .en       (ring_en),
    .expire   (ring_exp)
  );

  alarm_countdown #(.W(10)) u_snz (
    .clk      (CLK),
    .rst      (RESET),
    .load     (snz_load),
    .load_val (SNZ_LOAD),
    .en       (snz_en),
    .expire   (snz_exp)
  );

  // Next state; external clear beats keys, stop beats snooze.
  always_comb begin
    state_d    = state;
    snz_used_d = snz_used;
    dis_d      = 1'b0;
    stop_req   = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.DONE_SET && alarm_set)
          state_d = ARMED;
      end
      ARMED: begin
        if (!bus.DONE_SET)
          state_d = IDLE;
        else if (match)
          state_d = RING;
      end
      RING: begin
        stop_req = bus.STOP_KEY || ring_exp ||
                   (bus.SNOOZE_KEY &&
                    snz_used == SNZ_MAX);
        if (!bus.DONE_SET) begin
          state_d = IDLE;
        end else if (stop_req) begin
          state_d = IDLE;
          dis_d   = 1'b1;
        end else if (bus.SNOOZE_KEY) begin
          state_d    = SNOOZE;
          snz_used_d = snz_used + 2'd1;
        end
      end
      SNOOZE: begin
        if (!bus.DONE_SET) begin
          state_d = IDLE;
        end else if (bus.STOP_KEY) begin
          state_d = IDLE;
          dis_d   = 1'b1;
        end else if (snz_exp) begin
          state_d = RING;
        end
      end
      default: state_d = IDLE;
    endcase
    if (state_d == IDLE)
      snz_used_d = '0;
  end

  // Buzzer phase starts on at ring entry, flips per tick.
  always_comb begin
    phase_d = phase;
    if (ring_load)
      phase_d = 1'b1;
    else if (ring_en)
      phase_d = ~phase;
  end

  // State, snooze count and registered outputs.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state     <= IDLE;
      snz_used  <= '0;
      phase     <= 1'b0;
      ringing_q <= 1'b0;
      buzzer_q  <= 1'b0;
      snooze_q  <= 1'b0;
      dis_q     <= 1'b0;
    end else begin
      state     <= state_d;
      snz_used  <= snz_used_d;
      phase     <= phase_d;
      ringing_q <= state_d == RING;
      buzzer_q  <= state_d == RING && phase_d;
      snooze_q  <= state_d == SNOOZE;
      dis_q     <= dis_d;
    end
  end

  assign bus.RINGING         = ringing_q;
  assign bus.BUZZER          = buzzer_q;
  assign bus.SNOOZE_ACTIVE   = snooze_q;
  assign bus.SNOOZE_CNT      = snz_used;
  assign bus.DISABLE_TRIGGER = dis_q;

endmodule
